i4002_ram_x: RTL and testbench
==============================

# i4002_ram_x

Parametrised successor to the 4002 RAM/output chip model, built as a single-clock synchronous block. It tracks the 8-phase MCS-4 machine cycle from `sync` and decodes SRC and I/O instructions from the shared 4-bit bus. It also provides the RAM, status-character and output-port services with a configurable register count, output width and chip-select (metal option + `p0`). The data bus is split into in/out/enable, so a top level can merge several instances onto one bus.

## Interface
- `METAL_OPT`, 0, chip-select high bit (metal option: 0 = -1 part, 1 = -2 part).
- `NUM_REGS`, 4, registers implemented (1..4); each register holds 16 main characters and 4 status characters, all 4 bits.
- `OUT_WIDTH`, 4, implemented output-port bits (1..4).
- `cp2`  in  1  clock; one rising edge per machine-cycle phase.
- `reset`  in  1  synchronous, active-high.
- `sync`  in  1  high during the final phase (X3) of a cycle; next phase is A1.
- `cm`  in  1  memory control (CM-RAM for this bank).
- `p0`  in  1  hard-wired chip-select low bit.
- `data_in`  in  4  bus value sampled this phase.
- `data_out`  out  4  bus value driven when `data_oe`.
- `data_oe`  out  1  bus drive enable.
- `out`  out  OUT_WIDTH  output port.

## Operation
- Phase counter `ph`, 0..7 = A1 A2 A3 M1 M2 X1 X2 X3.
  - Advances on every `cp2` edge and wraps X3 -> A1.
  - `sync` high forces the next phase to A1 regardless of `ph`.
  - `locked` flag is cleared by reset and set by the first `sync`. While unlocked, no decode, writes or drive occur.
- Edge rule: "at phase P" means the `cp2` edge ending the cycle where `ph`==P. `data_in` is sampled there.
- At M1: latch `opr`=`data_in`. At M2: latch `opa`=`data_in`, and latch `io_cm`=`cm`.
- SRC: `opr`==0010 and `opa[0]`==1.
  - At X2 with `cm`=1: `sel` = (`data_in[3:2]`=={METAL_OPT,`p0`}) and (`data_in[1:0]` < NUM_REGS).
  - At X2: `reg_ptr`=`data_in[1:0]`.
  - At X3 with `cm`=1 and this chip selected: `chr_ptr`=`data_in`.
  - SRC with `cm`=0 at X2 leaves `sel` and the pointers unchanged.
  - A SRC addressing another chip clears `sel`.
- I/O: `opr`==1110 and `io_cm`==1 and `sel`==1. Actions happen in X2, keyed on `opa`:
  - 0000 WRM: mem[reg_ptr][chr_ptr] <= `data_in`.
  - 0001 WMP: `out` <= `data_in[OUT_WIDTH-1:0]`.
  - 01nn WR0-3: stat[reg_ptr][nn] <= `data_in`.
  - 1000 SBM, 1001 RDM, 1011 ADM: drive mem[reg_ptr][chr_ptr].
  - 11nn RD0-3: drive stat[reg_ptr][nn].
  - All other codes (WRR, WPM, RDR, WR/ROM ops) are ignored.
- Drive: `data_oe`=1 and `data_out` valid for exactly the X2 cycle, registered. `data_oe`=0 in every other phase.
- `opr`/`opa`/`io_cm` are cleared whenever `sync` forces A1 from a phase other than X3. This aborts partial decodes.

## Timing
- Reset (synchronous, has priority over all else) sets:
  - `ph`=X3, `locked`=0, `sel`=0, pointers=0, `opr`=`opa`=0.
  - All memory and status = 0.
  - `out`=0, `data_out`=0, `data_oe`=0.
- Reset asserted mid-cycle aborts any write. Nothing is driven the following cycle. Operation restarts only after the next `sync`.
- Write latency: the array/`out` updates on the X2 edge and is readable by a read in the next machine cycle's X2.
- Read latency: `data_oe` and `data_out` are asserted from the edge ending X1 until the edge ending X2.
- Selection persists across any number of machine cycles until the next SRC with `cm`=1.
- `chr_ptr` is 4 bits and is ignored beyond 15. `reg_ptr` >= NUM_REGS leaves the chip unselected, so it neither writes nor drives.
- `out` holds its value across selection changes; only WMP or reset changes it.

## Test plan
- Reset, then run cycles without `sync`: `data_oe`=0 and `out`=0 throughout; WRM is not executed.
- Configure `METAL_OPT`=0, `p0`=1. Issue SRC with X2=0110, X3=1010, then WRM with 0x5, then RDM: `data_oe`=1 during X2 only, `data_out`=0x5.
- Issue SRC with X2=1110 (chip 3): the chip deselects, a following RDM leaves `data_oe`=0, and a WRM leaves the array unchanged.
- WR2 with 0xC, then RD2: `data_out`=0xC. RD1 returns 0x0. WMP 0x9 with `OUT_WIDTH`=3 gives `out`=3'b001.
- Configure `NUM_REGS`=2 and SRC to register 3: no write and no drive. Then SRC to register 1: normal access resumes.
- Assert `sync` early at M2 of a WRM cycle: that write is dropped. Assert `reset` in X1 of an RDM: `data_oe` stays 0, and memory and `out` read 0 after re-sync.

Source files
------------

// File: rtl/i4002_ram_x.sv
// ---------------------------------------------------------------------------
// i4002_ram_x -- parametrised 4002-style RAM / output-port chip.
//
// The block tracks the 8-phase MCS-4 machine cycle from sync. It decodes SRC
// and I/O instructions seen on the shared 4-bit bus, and serves:
//   - main characters (16 per register),
//   - status characters (4 per register),
//   - an output port.
// The bus is split into in / out / enable so several instances can be merged
// onto one bus by the surrounding top level.
//
// Parameters
//   METAL_OPT  chip-select high bit (metal option)
//   NUM_REGS   implemented registers, 1..4
//   OUT_WIDTH  implemented output-port bits, 1..4
//
// Ports
//   cp2       clock, one rising edge per machine-cycle phase
//   reset     synchronous, active-high
//   sync      high during X3; the next phase is A1
//   cm        memory control line for this bank
//   p0        hard-wired chip-select low bit
//   data_in   bus value sampled on each edge
//   data_out  bus value, valid while data_oe is high
//   data_oe   bus drive enable (high only during X2 of a read)
//   out       output port
// ---------------------------------------------------------------------------
module i4002_ram_x #(
  parameter int METAL_OPT = 0,
  parameter int NUM_REGS  = 4,
  parameter int OUT_WIDTH = 4
) (
  input  logic                 cp2,
  input  logic                 reset,
  input  logic                 sync,
  input  logic                 cm,
  input  logic                 p0,
  input  logic [3:0]           data_in,
  output logic [3:0]           data_out,
  output logic                 data_oe,
  output logic [OUT_WIDTH-1:0] out
);

  localparam logic [2:0] PH_A1 = 3'd0;
  localparam logic [2:0] PH_M1 = 3'd3;
  localparam logic [2:0] PH_M2 = 3'd4;
  localparam logic [2:0] PH_X1 = 3'd5;
  localparam logic [2:0] PH_X2 = 3'd6;
  localparam logic [2:0] PH_X3 = 3'd7;

  localparam logic       METAL_BIT  = 1'(METAL_OPT);
  localparam logic [2:0] NUM_REGS_W = 3'(NUM_REGS);

  logic [2:0]           ph_reg;
  logic                 locked_reg;
  logic [3:0]           opr_reg;
  logic [3:0]           opa_reg;
  logic                 io_cm_reg;
  logic                 sel_reg;
  logic [1:0]           reg_ptr_reg;
  logic [3:0]           chr_ptr_reg;
  logic [OUT_WIDTH-1:0] out_reg;
  logic [3:0]           data_out_reg;
  logic                 data_oe_reg;

  // Per-register read ports; unimplemented registers read as zero.
  logic [3:0] mem_rd  [4];
  logic [3:0] stat_rd [4];

  logic       is_src;
  logic       io_active;
  logic       chip_match;
  logic       at_x1;
  logic       at_x2;
  logic       wr_main;
  logic       wr_stat;
  logic       wr_out;
  logic       rd_req;
  logic [3:0] rd_val;

  always_comb begin
    is_src     = (opr_reg == 4'b0010) && opa_reg[0];
    io_active  = locked_reg && (opr_reg == 4'b1110) && io_cm_reg && sel_reg;
    chip_match = (data_in[3:2] == {METAL_BIT, p0}) &&
                 ({1'b0, data_in[1:0]} < NUM_REGS_W);
    // A sync landing on X1/X2 aborts the cycle, so it must not act there.
    at_x1      = locked_reg && (ph_reg == PH_X1) && !sync;
    at_x2      = locked_reg && (ph_reg == PH_X2) && !sync;
    wr_main    = io_active && at_x2 && (opa_reg == 4'b0000);
    wr_out     = io_active && at_x2 && (opa_reg == 4'b0001);
    wr_stat    = io_active && at_x2 && (opa_reg[3:2] == 2'b01);
    // SBM/RDM/ADM (1000, 1001, 1011) and RD0-3 (11nn). 1010 (RDR) is not ours.
    rd_req     = io_active && at_x1 &&
                 ((opa_reg == 4'b1000) || (opa_reg == 4'b1001) ||
                  (opa_reg == 4'b1011) || (opa_reg[3:2] == 2'b11));
    rd_val     = opa_reg[2] ? stat_rd[reg_ptr_reg] : mem_rd[reg_ptr_reg];
  end

  // Phase tracking, instruction latches, selection and bus drive.
  always_ff @(posedge cp2) begin
    if (reset) begin
      ph_reg       <= PH_X3;
      locked_reg   <= 1'b0;
      opr_reg      <= '0;
      opa_reg      <= '0;
      io_cm_reg    <= 1'b0;
      sel_reg      <= 1'b0;
      reg_ptr_reg  <= '0;
      chr_ptr_reg  <= '0;
      out_reg      <= '0;
      data_out_reg <= '0;
      data_oe_reg  <= 1'b0;
    end else begin
      data_oe_reg <= 1'b0;

      if (sync) begin
        ph_reg     <= PH_A1;
        locked_reg <= 1'b1;
        // An early sync throws away whatever was half-decoded.
        if (ph_reg != PH_X3) begin
          opr_reg   <= '0;
          opa_reg   <= '0;
          io_cm_reg <= 1'b0;
        end
      end else begin
        ph_reg <= ph_reg + 3'd1;
        if (locked_reg && (ph_reg == PH_M1)) begin
          opr_reg <= data_in;
        end
        if (locked_reg && (ph_reg == PH_M2)) begin
          opa_reg   <= data_in;
          io_cm_reg <= cm;
        end
      end

      // SRC: chip/register address in X2, character address in X3.
      if (at_x2 && is_src && cm) begin
        sel_reg     <= chip_match;
        reg_ptr_reg <= data_in[1:0];
      end
      // sel_reg here already reflects this SRC's X2 decision.
      if (locked_reg && (ph_reg == PH_X3) && is_src && cm && sel_reg) begin
        chr_ptr_reg <= data_in;
      end

      if (rd_req) begin
        data_oe_reg  <= 1'b1;
        data_out_reg <= rd_val;
      end

      if (wr_out) begin
        out_reg <= data_in[OUT_WIDTH-1:0];
      end
    end
  end

  // One storage block per implemented register.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_reg
      if (gi < NUM_REGS) begin : g_impl
        logic [3:0] main_mem [16];
        logic [3:0] stat_mem [4];

        always_ff @(posedge cp2) begin
          if (reset) begin
            for (int i = 0; i < 16; i++) main_mem[i] <= '0;
            for (int i = 0; i < 4; i++)  stat_mem[i] <= '0;
          end else begin
            if (wr_main && (reg_ptr_reg == 2'(gi))) begin
              main_mem[chr_ptr_reg] <= data_in;
            end
            if (wr_stat && (reg_ptr_reg == 2'(gi))) begin
              stat_mem[opa_reg[1:0]] <= data_in;
            end
          end
        end

        assign mem_rd[gi]  = main_mem[chr_ptr_reg];
        assign stat_rd[gi] = stat_mem[opa_reg[1:0]];
      end else begin : g_absent
        assign mem_rd[gi]  = 4'h0;
        assign stat_rd[gi] = 4'h0;
      end
    end
  endgenerate

  assign data_out = data_out_reg;
  assign data_oe  = data_oe_reg;
  assign out      = out_reg;

endmodule

// File: tb/tb_i4002_ram_x.sv
// ---------------------------------------------------------------------------
// tb_i4002_ram_x -- directed bench for i4002_ram_x.
//
// DUT configuration:
//   METAL_OPT=0, p0=1  -> chip 01
//   NUM_REGS=3         -> register 3 is out of range
//   OUT_WIDTH=3
//
// Every machine cycle is driven phase by phase. data_oe is sampled after each
// edge into an 8-bit mask, where bit p is the enable during the phase after p.
// A read must therefore give mask 8'h20 (bit 5, i.e. driven during X2).
// ---------------------------------------------------------------------------
module tb_i4002_ram_x;

  logic       cp2 = 1'b0;
  logic       reset = 1'b0;
  logic       sync = 1'b0;
  logic       cm = 1'b0;
  logic       p0 = 1'b1;
  logic [3:0] data_in = 4'h0;
  logic [3:0] data_out;
  logic       data_oe;
  logic [2:0] out;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] oe_m;
  logic [3:0] dq;

  localparam logic [7:0] OE_READ = 8'h20;

  i4002_ram_x #(
    .METAL_OPT(0),
    .NUM_REGS (3),
    .OUT_WIDTH(3)
  ) dut (
    .cp2     (cp2),
    .reset   (reset),
    .sync    (sync),
    .cm      (cm),
    .p0      (p0),
    .data_in (data_in),
    .data_out(data_out),
    .data_oe (data_oe),
    .out     (out)
  );

  always #5 cp2 = ~cp2;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  // One machine cycle starting at A1.
  // Stops early right after the edge where sync_ph or reset_ph applies.
  task automatic mcycle(input logic [3:0] opr_v, input logic [3:0] opa_v,
                        input logic [3:0] x2_v, input logic [3:0] x3_v,
                        input logic cm_v, input int sync_ph, input int reset_ph,
                        output logic [7:0] mask, output logic [3:0] dout);
    mask = '0;
    dout = '0;
    for (int p = 0; p < 8; p++) begin
      data_in = 4'h0;
      cm      = 1'b0;
      sync    = (p == sync_ph);
      reset   = (p == reset_ph);
      case (p)
        3: data_in = opr_v;
        4: begin data_in = opa_v; cm = cm_v; end
        6: begin data_in = x2_v;  cm = cm_v; end
        7: begin data_in = x3_v;  cm = cm_v; end
        default: ;
      endcase
      @(posedge cp2);
      #1;
      mask[p] = data_oe;
      if (p == 5) dout = data_out;
      sync  = 1'b0;
      reset = 1'b0;
      if (p == sync_ph || p == reset_ph) break;
    end
  endtask

  task automatic src(input logic [3:0] x2, input logic [3:0] x3);
    mcycle(4'b0010, 4'b0001, x2, x3, 1'b1, 7, 99, oe_m, dq);
  endtask

  task automatic io(input logic [3:0] opa_v, input logic [3:0] d);
    mcycle(4'b1110, opa_v, d, 4'h0, 1'b1, 7, 99, oe_m, dq);
  endtask

  task automatic idle_edge();
    data_in = 4'h0;
    cm      = 1'b0;
    sync    = 1'b0;
    @(posedge cp2);
    #1;
  endtask

  initial begin
    // Reset, then check the reset state.
    reset = 1'b1;
    repeat (3) @(posedge cp2);
    #1;
    reset = 1'b0;
    check("rst_oe", data_oe, 0);
    check("rst_dout", data_out, 0);
    check("rst_out", out, 0);
    idle_edge();  // leaves X3, next phase is A1

    // Unlocked: no sync yet, so nothing may decode, write or drive.
    mcycle(4'b0010, 4'b0001, 4'b0110, 4'b1010, 1'b1, 8, 99, oe_m, dq);
    check("unlk_src_oe", oe_m, 0);
    mcycle(4'b1110, 4'b0000, 4'h5, 4'h0, 1'b1, 8, 99, oe_m, dq);
    check("unlk_wrm_oe", oe_m, 0);
    mcycle(4'b1110, 4'b0001, 4'h7, 4'h0, 1'b1, 8, 99, oe_m, dq);
    check("unlk_wmp_out", out, 0);
    mcycle(4'b1110, 4'b1001, 4'h0, 4'h0, 1'b1, 8, 99, oe_m, dq);
    check("unlk_rdm_oe", oe_m, 0);

    // First sync locks the phase tracker.
    mcycle(4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 7, 99, oe_m, dq);

    // SRC chip 01, reg 2, chr 10. Array must still be 0 (unlocked WRM dropped).
    src(4'b0110, 4'b1010);
    io(4'b1001, 4'h0);
    check("rdm0_oe", oe_m, OE_READ);
    check("rdm0_dat", dq, 4'h0);

    // WRM 5 then read back.
    io(4'b0000, 4'h5);
    check("wrm_oe", oe_m, 0);
    io(4'b1001, 4'h0);
    check("rdm_oe", oe_m, OE_READ);
    check("rdm_dat", dq, 4'h5);
    io(4'b1011, 4'h0);
    check("adm_dat", dq, 4'h5);
    io(4'b1000, 4'h0);
    check("sbm_oe", oe_m, OE_READ);

    // Status characters.
    io(4'b0110, 4'hC);
    io(4'b1110, 4'h0);
    check("rd2_dat", dq, 4'hC);
    io(4'b1101, 4'h0);
    check("rd1_dat", dq, 4'h0);
    check("rd1_oe", oe_m, OE_READ);

    // Output port, 3 implemented bits.
    io(4'b0001, 4'h9);
    check("wmp_out", out, 3'b001);
    check("wmp_oe", oe_m, 0);

    // RDR belongs to the ROM side; it must not drive.
    io(4'b1010, 4'h0);
    check("rdr_oe", oe_m, 0);

    // SRC with cm=0 keeps the current selection.
    mcycle(4'b0010, 4'b0001, 4'b1110, 4'b0000, 1'b0, 7, 99, oe_m, dq);
    io(4'b1001, 4'h0);
    check("srccm0_dat", dq, 4'h5);

    // SRC to chip 3 deselects: no drive, no write, out holds.
    src(4'b1110, 4'b1010);
    io(4'b1001, 4'h0);
    check("desel_oe", oe_m, 0);
    io(4'b0000, 4'hF);
    check("desel_out", out, 3'b001);
    src(4'b0110, 4'b1010);
    io(4'b1001, 4'h0);
    check("resel_dat", dq, 4'h5);

    // Register 3 is beyond NUM_REGS=3: unselected.
    src(4'b0111, 4'b0000);
    io(4'b0000, 4'hA);
    io(4'b1001, 4'h0);
    check("reg3_oe", oe_m, 0);

    // Register 1 works normally; register 2 chr 0 stays independent.
    src(4'b0101, 4'b0000);
    io(4'b0000, 4'h3);
    io(4'b1001, 4'h0);
    check("reg1_dat", dq, 4'h3);
    src(4'b0110, 4'b0000);
    io(4'b1001, 4'h0);
    check("reg2c0_dat", dq, 4'h0);

    // Early sync at M2 of a WRM drops the write.
    src(4'b0110, 4'b1010);
    mcycle(4'b1110, 4'b0000, 4'hE, 4'h0, 1'b1, 4, 99, oe_m, dq);
    io(4'b1001, 4'h0);
    check("abort_dat", dq, 4'h5);
    check("abort_oe", oe_m, OE_READ);

    // Reset in X1 of an RDM: no drive, then everything reads back as zero.
    mcycle(4'b1110, 4'b1001, 4'h0, 4'h0, 1'b1, 7, 5, oe_m, dq);
    check("rstx1_oe", oe_m, 0);
    idle_edge();
    check("rstx1_next_oe", data_oe, 0);
    mcycle(4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 7, 99, oe_m, dq);
    src(4'b0110, 4'b1010);
    io(4'b1001, 4'h0);
    check("rstx1_mem", dq, 4'h0);
    check("rstx1_mem_oe", oe_m, OE_READ);
    check("rstx1_out", out, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
